// File: rtl/glbl_pkg.sv
// Shared types and defaults for the host-side start/done control path.
// Also reused by glbl_ctrl-side benches.
package glbl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } glbl_state_e;

  localparam int CNT_W_DEF   = 8;
  localparam int TO_W_DEF    = 20;
  localparam int TIMEOUT_DEF = 1000000;

endpackage

// File: rtl/glbl_edge_det.sv
// Registered rising-edge detector; a held-high level yields one event.
module glbl_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;
  logic d_d;

  always_comb begin
    d_d = d_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_d;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/glbl_start_ctrl.sv
// Host start pulse generation, run tracking, done capture and watchdog.
module glbl_start_ctrl
  import glbl_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEF,
  parameter int TO_W           = TO_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_req_i,
  input  logic             done_intr_i,
  input  logic             irq_ack_i,
  output logic             start_o,
  output logic             busy_o,
  output logic             done_status_o,
  output logic             timeout_o,
  output logic             overrun_o,
  output logic [CNT_W-1:0] done_cnt_o
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  glbl_state_e      state_q, state_d;
  logic [TO_W-1:0]  timer_q, timer_d;
  logic             done_q, done_d;
  logic             to_q, to_d;
  logic             ovr_q, ovr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic req_rise;
  logic done_rise;

  glbl_edge_det u_req_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (start_req_i),
    .rise_o (req_rise)
  );

  glbl_edge_det u_intr_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (done_intr_i),
    .rise_o (done_rise)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    done_d  = done_q;
    to_d    = to_q;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_rise) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        timer_d = '0;
        state_d = ST_RUN;
        if (req_rise) begin
          ovr_d = 1'b1;
        end
      end
      ST_RUN: begin
        timer_d = timer_q + TO_W'(1);
        if (req_rise) begin
          ovr_d = 1'b1;
        end
        // done outranks a timeout landing on the same cycle
        if (done_rise) begin
          done_d  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_DONE;
        end else if (timer_q == TO_LAST) begin
          to_d    = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // an ack also wipes an overrun raised in this same cycle
        if (irq_ack_i) begin
          done_d  = 1'b0;
          to_d    = 1'b0;
          ovr_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (req_rise) begin
          ovr_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      done_q  <= done_d;
      to_q    <= to_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign start_o       = (state_q == ST_START);
  assign busy_o        = (state_q == ST_START) | (state_q == ST_RUN);
  assign done_status_o = done_q;
  assign timeout_o     = to_q;
  assign overrun_o     = ovr_q;
  assign done_cnt_o    = cnt_q;

endmodule

// File: tb/tb_glbl_start_ctrl.sv
// Bench for glbl_start_ctrl: directed scenarios plus random traffic vs a model.
module tb_glbl_start_ctrl;

  localparam int CW = 2;
  localparam int TW = 8;
  localparam int TO = 16;

  localparam int P_IDLE  = 0;
  localparam int P_START = 1;
  localparam int P_RUN   = 2;
  localparam int P_DONE  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          intr = 1'b0;
  logic          ack = 1'b0;
  logic          start_o, busy_o, done_o, to_o, ovr_o;
  logic [CW-1:0] cnt_o;

  int n_tests = 0;
  int n_fail  = 0;
  int n_start = 0;

  int ph      = P_IDLE;
  int run_len = 0;
  int m_cnt   = 0;
  bit m_done, m_to, m_ovr, p_req, p_intr;

  glbl_start_ctrl #(
    .CNT_W          (CW),
    .TO_W           (TW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_req_i   (req),
    .done_intr_i   (intr),
    .irq_ack_i     (ack),
    .start_o       (start_o),
    .busy_o        (busy_o),
    .done_status_o (done_o),
    .timeout_o     (to_o),
    .overrun_o     (ovr_o),
    .done_cnt_o    (cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit i, input bit a,
                            input bit rs);
    bit rr, dr;
    rr = r && !p_req;
    dr = i && !p_intr;
    if (rs) begin
      ph = P_IDLE; run_len = 0; m_cnt = 0;
      m_done = 0; m_to = 0; m_ovr = 0;
      p_req = 0; p_intr = 0;
      return;
    end
    if (ph == P_IDLE) begin
      if (rr) ph = P_START;
    end else if (ph == P_START) begin
      if (rr) m_ovr = 1;
      run_len = 0;
      ph = P_RUN;
    end else if (ph == P_RUN) begin
      if (rr) m_ovr = 1;
      run_len++;
      if (dr) begin
        m_done = 1;
        m_cnt = (m_cnt + 1) % (1 << CW);
        ph = P_DONE;
      end else if (run_len == TO) begin
        m_to = 1;
        ph = P_DONE;
      end
    end else begin
      if (a) begin
        m_done = 0; m_to = 0; m_ovr = 0;
        ph = P_IDLE;
      end else if (rr) begin
        m_ovr = 1;
      end
    end
    p_req = r;
    p_intr = i;
  endtask

  task automatic tick(input bit r, input bit i, input bit a, input bit rs);
    req = r; intr = i; ack = a; rst = rs;
    model_step(r, i, a, rs);
    @(negedge clk);
    if (start_o === 1'b1) n_start++;
    chk("start", start_o, ph == P_START);
    chk("busy", busy_o, ph == P_START || ph == P_RUN);
    chk("done", done_o, m_done);
    chk("timeout", to_o, m_to);
    chk("overrun", ovr_o, m_ovr);
    chk("count", cnt_o, m_cnt);
  endtask

  task automatic intr_pulse(input bit r);
    for (int k = 0; k < 6; k++) tick(r, 1, 0, 0);
    tick(r, 0, 0, 0);
  endtask

  initial begin
    int s0, c0, left;
    bit rr_lvl, ack_b, rst_b, ib;
    // reset: two cycles, then everything must read zero
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    chk("rst_cnt", cnt_o, 0);
    chk("rst_busy", busy_o, 0);

    // basic run: req rise -> start next cycle -> done -> ack
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("basic_start", start_o, 1);
    tick(1, 0, 0, 0);
    chk("basic_start_once", start_o, 0);
    chk("basic_busy", busy_o, 1);
    for (int k = 0; k < 8; k++) tick(1, 0, 0, 0);
    intr_pulse(1);
    chk("basic_done", done_o, 1);
    chk("basic_cnt", cnt_o, 1);
    chk("basic_idle_busy", busy_o, 0);
    tick(1, 0, 1, 0);
    chk("basic_ack", done_o, 0);

    // held levels: one start, one increment
    tick(0, 0, 0, 0);
    s0 = n_start; c0 = cnt_o;
    for (int k = 0; k < 10; k++) tick(1, 0, 0, 0);
    intr_pulse(1);
    for (int k = 0; k < 33; k++) tick(1, 0, 0, 0);
    chk("held_starts", n_start - s0, 1);
    chk("held_cnt", cnt_o, (c0 + 1) % 4);
    tick(0, 0, 1, 0);

    // timeout, then a late done pulse in DONE is ignored
    c0 = cnt_o;
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    for (int k = 0; k < TO; k++) tick(1, 0, 0, 0);
    chk("to_flag", to_o, 1);
    chk("to_cnt", cnt_o, c0);
    intr_pulse(1);
    chk("to_late_done", done_o, 0);
    tick(0, 0, 1, 0);

    // collision: done rise on the very cycle the timer expires
    c0 = cnt_o;
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    for (int k = 0; k < TO - 1; k++) tick(1, 0, 0, 0);
    tick(1, 1, 0, 0);
    chk("col_done", done_o, 1);
    chk("col_to", to_o, 0);
    chk("col_cnt", cnt_o, (c0 + 1) % 4);
    tick(0, 1, 1, 0);
    tick(0, 0, 0, 0);

    // overrun during RUN, spurious done in IDLE, ack clears overrun
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    s0 = n_start;
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("ovr_set", ovr_o, 1);
    intr_pulse(1);
    chk("ovr_no_start", n_start - s0, 0);
    tick(0, 0, 1, 0);
    chk("ovr_clr", ovr_o, 0);
    intr_pulse(0);
    chk("spur_done", done_o, 0);

    // ack and req rise in the same DONE cycle
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    intr_pulse(0);
    tick(1, 0, 1, 0);
    chk("ackreq_ovr", ovr_o, 0);
    chk("ackreq_busy", busy_o, 0);

    // wrap: five runs after reset gives count 1 with a 2-bit counter
    tick(0, 0, 0, 1);
    for (int r = 0; r < 5; r++) begin
      tick(1, 0, 0, 0);
      tick(0, 0, 0, 0);
      intr_pulse(0);
      tick(0, 0, 1, 0);
    end
    chk("wrap_cnt", cnt_o, 1);

    // reset mid-run aborts silently
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    chk("rrun_busy", busy_o, 0);
    chk("rrun_start", start_o, 0);
    chk("rrun_cnt", cnt_o, 0);

    // random traffic
    left = 0;
    rr_lvl = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0) rr_lvl = ~rr_lvl;
      if (left == 0 && $urandom_range(0, 24) == 0) left = 6;
      ib = (left > 0);
      if (left > 0) left--;
      ack_b = ($urandom_range(0, 5) == 0);
      rst_b = ($urandom_range(0, 299) == 0);
      tick(rr_lvl, ib, ack_b, rst_b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
